// File: rtl/peripheral_mpram_arbiter.sv
// peripheral_mpram_arbiter: round-robin arbiter sharing one single-port memory BIU among NPORTS requesters.
// Optional bus-lock support is compiled in with PERIPHERAL_MPRAM_ARBITER_LOCK_EN.
module peripheral_mpram_arbiter #(
    parameter int PLEN   = 64,
    parameter int XLEN   = 64,
    parameter int NPORTS = 4
) (
    input  logic                     rst,
    input  logic                     clk,
    input  logic [NPORTS-1:0]        req_i,
    input  logic [NPORTS-1:0]        we_i,
    input  logic [3*NPORTS-1:0]      be_i,
    input  logic [PLEN*NPORTS-1:0]   addr_i,
    input  logic [XLEN*NPORTS-1:0]   data_i,
    input  logic [NPORTS-1:0]        lock_i,
    output logic [NPORTS-1:0]        gnt_o,
    output logic [NPORTS-1:0]        ack_o,
    output logic [XLEN-1:0]          data_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [2:0]               mem_be_o,
    output logic [PLEN-1:0]          mem_addr_o,
    output logic [XLEN-1:0]          mem_data_o,
    input  logic [XLEN-1:0]          mem_data_i
);
    localparam int PW = $clog2(NPORTS);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nxt;
    logic [PW-1:0] ptr, win, sel, pick;
    logic found, go, lock_q, lock_now;
    logic cmd_we, pick_we;
    logic [2:0] cmd_be, pick_be;
    logic [PLEN-1:0] cmd_addr, pick_addr;
    logic [XLEN-1:0] cmd_data, pick_data, data_q;
    logic [NPORTS-1:0] win_oh;
`ifdef PERIPHERAL_MPRAM_ARBITER_LOCK_EN
    // a locking winner still requesting keeps the bus for its next access
    assign lock_now = lock_i[win] & req_i[win];
    always_ff @(posedge clk or negedge rst)
        if (!rst) lock_q <= 1'b0;
        else if (state == RESP) lock_q <= lock_now;
`else
    logic unused_lock;
    assign lock_now    = 1'b0;
    assign lock_q      = 1'b0;
    assign unused_lock = ^lock_i;
`endif
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < NPORTS; i++)
            if (!found && req_i[(int'(ptr) + i) % NPORTS]) begin
                sel   = PW'((int'(ptr) + i) % NPORTS);
                found = 1'b1;
            end
    end
    assign go   = lock_q | found;
    assign pick = lock_q ? win : sel;
    always_comb begin
        pick_we   = 1'b0;
        pick_be   = '0;
        pick_addr = '0;
        pick_data = '0;
        for (int i = 0; i < NPORTS; i++)
            if (pick == PW'(i)) begin
                pick_we   = we_i[i];
                pick_be   = be_i[3*i +: 3];
                pick_addr = addr_i[PLEN*i +: PLEN];
                pick_data = data_i[XLEN*i +: XLEN];
            end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    assign win_oh = NPORTS'(1) << win;
    always_comb begin
        state_nxt = state;
        gnt_o     = '0;
        ack_o     = '0;
        mem_req_o = 1'b0;
        data_o    = data_q;
        case (state)
            IDLE:  state_nxt = go ? ISSUE : IDLE;
            ISSUE: begin
                state_nxt = RESP;
                gnt_o     = win_oh;
                mem_req_o = 1'b1;
            end
            RESP:  begin
                state_nxt = IDLE;
                ack_o     = win_oh;
                data_o    = cmd_we ? data_q : mem_data_i;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            ptr      <= '0;
            win      <= '0;
            cmd_we   <= 1'b0;
            cmd_be   <= '0;
            cmd_addr <= '0;
            cmd_data <= '0;
            data_q   <= '0;
        end else begin
            if (state == IDLE && go) begin
                win      <= pick;
                cmd_we   <= pick_we;
                cmd_be   <= pick_be;
                cmd_addr <= pick_addr;
                cmd_data <= pick_data;
            end
            if (state == RESP) begin
                ptr <= lock_now ? ptr : (win == PW'(NPORTS - 1)) ? '0 : win + 1'b1;
                if (!cmd_we) data_q <= mem_data_i;
            end
        end
    assign mem_we_o   = cmd_we;
    assign mem_be_o   = cmd_be;
    assign mem_addr_o = cmd_addr;
    assign mem_data_o = cmd_data;
endmodule

// File: tb/tb_peripheral_mpram_arbiter.sv
// tb_peripheral_mpram_arbiter: vector table, directed corner sequences and a random run against a transaction-level model.
module tb_peripheral_mpram_arbiter;
    localparam int NP = 4;
    logic clk = 1'b0, rst = 1'b0;
    logic [NP-1:0] req_i = '0, we_i = '0, lock_i = '0;
    logic [3*NP-1:0] be_i = '0;
    logic [64*NP-1:0] addr_i = '0;
    logic [64*NP-1:0] data_i = '0;
    logic [NP-1:0] gnt_o, ack_o;
    logic [63:0] data_o, mem_addr_o, mem_data_o, mem_data_i;
    logic mem_req_o, mem_we_o;
    logic [2:0] mem_be_o;
    logic [63:0] mem [256];
    logic mem_init = 1'b0;
    int compared = 0, mismatched = 0;
    always #5 clk = ~clk;
    peripheral_mpram_arbiter #(.PLEN(64), .XLEN(64), .NPORTS(NP)) dut (
        .rst(rst), .clk(clk), .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i),
        .data_i(data_i), .lock_i(lock_i), .gnt_o(gnt_o), .ack_o(ack_o), .data_o(data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );
    function automatic logic [63:0] init_val(int i);
        return (i == 16) ? 64'hDEAD_BEEF : 64'h0101_0101_0101_0101 * 64'(i);
    endfunction
    // memory BIU: read data one cycle after the address is sampled
    always @(posedge clk) begin
        mem_data_i <= mem[mem_addr_o[7:0]];
        if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        else if (mem_req_o && mem_we_o) mem[mem_addr_o[7:0]] <= mem_data_o;
    end
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic check_zero(string tag);
        check({tag, "_gnt"}, 64'(gnt_o), 0);
        check({tag, "_ack"}, 64'(ack_o), 0);
        check({tag, "_mem_req"}, 64'(mem_req_o), 0);
        check({tag, "_mem_we"}, 64'(mem_we_o), 0);
        check({tag, "_mem_be"}, 64'(mem_be_o), 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_mem_data"}, mem_data_o, 0);
        check({tag, "_data_o"}, data_o, 0);
    endtask
    task automatic drive(int p, logic we, logic [2:0] be, logic [63:0] addr, logic [63:0] data);
        req_i[p] = 1'b1;
        we_i[p] = we;
        be_i[3*p +: 3] = be;
        addr_i[64*p +: 64] = addr;
        data_i[64*p +: 64] = data;
    endtask
    function automatic int rr(logic [NP-1:0] r, int p);
        for (int i = 0; i < NP; i++) if (r[(p + i) % NP]) return (p + i) % NP;
        return -1;
    endfunction
    typedef struct {
        int port;
        logic we;
        logic [2:0] be;
        logic [63:0] addr, data, exp;
    } vec_t;
    vec_t vec [7];
    initial begin
        int exp_port [5];
        vec[0] = '{2, 1'b0, 3'b011, 64'h10, 64'h0,                   64'hDEAD_BEEF};
        vec[1] = '{1, 1'b1, 3'b001, 64'h05, 64'h1234,                64'hDEAD_BEEF};
        vec[2] = '{0, 1'b0, 3'b001, 64'h05, 64'h0,                   64'h1234};
        vec[3] = '{3, 1'b1, 3'b111, 64'h20, 64'hCAFE_F00D_1234_5678, 64'h1234};
        vec[4] = '{2, 1'b0, 3'b111, 64'h20, 64'h0,                   64'hCAFE_F00D_1234_5678};
        vec[5] = '{0, 1'b1, 3'b010, 64'h10, 64'h55,                  64'hCAFE_F00D_1234_5678};
        vec[6] = '{1, 1'b0, 3'b000, 64'h10, 64'h0,                   64'h55};
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check_zero("rst");
        req_i = '1;
        @(negedge clk);
        check_zero("rst_req");
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("rr_gnt_c%0d", c), 64'(gnt_o), (c % 3 == 1) ? 64'(1 << ((c / 3) % 4)) : 64'd0);
        end
        req_i = '0;
        for (int k = 0; k < 7; k++) begin
            drive(vec[k].port, vec[k].we, vec[k].be, vec[k].addr, vec[k].data);
            @(negedge clk);
            check($sformatf("v%0d_gnt", k), 64'(gnt_o), 64'(1 << vec[k].port));
            check($sformatf("v%0d_mem_req", k), 64'(mem_req_o), 1);
            check($sformatf("v%0d_mem_we", k), 64'(mem_we_o), 64'(vec[k].we));
            check($sformatf("v%0d_mem_be", k), 64'(mem_be_o), 64'(vec[k].be));
            check($sformatf("v%0d_mem_addr", k), mem_addr_o, vec[k].addr);
            check($sformatf("v%0d_mem_data", k), mem_data_o, vec[k].data);
            @(posedge clk);
            #1 req_i = '0;
            we_i = '0;
            @(negedge clk);
            check($sformatf("v%0d_ack", k), 64'(ack_o), 64'(1 << vec[k].port));
            check($sformatf("v%0d_resp_gnt", k), 64'(gnt_o), 0);
            check($sformatf("v%0d_resp_mem_req", k), 64'(mem_req_o), 0);
            check($sformatf("v%0d_resp_data", k), data_o, vec[k].exp);
            @(negedge clk);
            check($sformatf("v%0d_idle_ack", k), 64'(ack_o), 0);
            check($sformatf("v%0d_idle_data", k), data_o, vec[k].exp);
        end
        // a request raised only during another port's response is never granted
        drive(1, 1'b0, 3'b000, 64'h05, 64'h0);
        @(negedge clk);
        check("wd_gnt1", 64'(gnt_o), 64'b0010);
        @(posedge clk);
        #1 req_i = 4'b0001;
        @(negedge clk);
        check("wd_ack1", 64'(ack_o), 64'b0010);
        check("wd_data", data_o, 64'h1234);
        @(posedge clk);
        #1 req_i = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("wd_no_gnt_c%0d", c), 64'(gnt_o), 0);
        end
        // reset during the issue cycle of a write aborts it
        drive(3, 1'b1, 3'b111, 64'h30, 64'hBAD);
        @(negedge clk);
        check("ab_gnt3", 64'(gnt_o), 64'b1000);
        #1 rst = 1'b0;
        req_i = '0;
        we_i = '0;
        #1 check_zero("abort");
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("ab_ack_c%0d", c), 64'(ack_o), 0);
            check($sformatf("ab_gnt_c%0d", c), 64'(gnt_o), 0);
        end
        check("ab_mem_kept", mem[8'h30], init_val(48));
`ifdef PERIPHERAL_MPRAM_ARBITER_LOCK_EN
        exp_port = '{0, 1, 1, 1, 2};
        req_i = '1;
        lock_i = 4'b0010;
        for (int c = 1; c < 14; c++) begin
            @(negedge clk);
            check($sformatf("lk_gnt_c%0d", c), 64'(gnt_o), (c % 3 == 1) ? 64'(1 << exp_port[c / 3]) : 64'd0);
            if (c == 10) lock_i = '0;
        end
        req_i = '0;
        lock_i = '0;
`else
        exp_port = '{0, 0, 0, 0, 0};
`endif
        // random traffic against a transaction-level model
        rst = 1'b0;
        mem_init = 1'b1;
        @(posedge clk);
        #1 mem_init = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        begin
            logic [63:0] ref_mem [256];
            logic [63:0] held, out_addr, out_data;
            logic [NP-1:0] prev_req;
            logic out_we;
            int mptr, last, out_port, granted, w;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            held = 0;
            mptr = 0;
            last = -100;
            out_port = 0;
            out_we = 0;
            out_addr = 0;
            out_data = 0;
            granted = -1;
            for (int c = 0; c < 600; c++) begin
                @(posedge clk);
                #1 prev_req = req_i;
                if (granted >= 0) req_i[granted] = 1'b0;
                granted = -1;
                for (int p = 0; p < NP; p++)
                    if (!req_i[p] && $urandom_range(3) == 0)
                        drive(p, 1'($urandom_range(1)), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
                @(negedge clk);
                if (c == last + 1 && !out_we) held = ref_mem[out_addr[7:0]];
                check("rnd_ack", 64'(ack_o), (c == last + 1) ? 64'(1 << out_port) : 64'd0);
                check("rnd_data", data_o, held);
                w = (prev_req != 0 && c - last >= 3) ? rr(prev_req, mptr) : -1;
                check("rnd_gnt", 64'(gnt_o), (w >= 0) ? 64'(1 << w) : 64'd0);
                check("rnd_mem_req", 64'(mem_req_o), 64'(w >= 0));
                if (w >= 0) begin
                    last = c;
                    mptr = (w + 1) % NP;
                    out_port = w;
                    out_we = we_i[w];
                    out_addr = addr_i[64*w +: 64];
                    out_data = data_i[64*w +: 64];
                    check("rnd_mem_we", 64'(mem_we_o), 64'(out_we));
                    check("rnd_mem_be", 64'(mem_be_o), 64'(be_i[3*w +: 3]));
                    check("rnd_mem_addr", mem_addr_o, out_addr);
                    check("rnd_mem_data", mem_data_o, out_data);
                    if (out_we) ref_mem[out_addr[7:0]] = out_data;
                    granted = w;
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
